shift_arb: RTL and testbench
============================

# shift_arb

Round-robin arbiter and sequencer that shares one registered shift unit between two requesters. Each requester presents an operand, a shift amount and a shift opcode over a valid/ready handshake. The block grants one request per cycle, executes it in a two-stage pipeline and returns the ID-tagged result through a 2-entry output FIFO with its own valid/ready handshake. It sits between the operation-issue logic and the shared shifter datapath, so the shift semantics (logical/arithmetic, signed/unsigned operand) match the shift operators used throughout the design.

## Interface

Parameters:
- W, 8, operand/result width
- SW, 4, shift-amount width (amount is always unsigned)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready
- req0_op  in  2  00 logical left, 01 logical right, 10 arith left, 11 arith right
- req0_signed  in  1  operand is signed (affects only op 11)
- req0_a  in  W  operand
- req0_amt  in  SW  shift amount
- req1_valid, req1_ready, req1_op, req1_signed, req1_a, req1_amt: same as requester 0
- res_valid  out  1  res_id/res_y hold a result
- res_ready  in  1  consumer takes result when valid&ready
- res_id  out  1  requester that issued the result
- res_y  out  W  shifted result

## Operation

- Round-robin grant, with a last_grant register (reset value 1, so req0 wins first).
  - Both valid: grant the requester that is not last_grant.
  - One valid: grant that one.
  - last_grant updates only on an accepted handshake.
- Space check: space = (fifo_count + inflight − (res_valid & res_ready)) < 2. inflight = issue register occupied.
  - reqX_ready = grantX & space.
  - There is a combinational path from res_ready to reqX_ready. This path is intentional; it gives full throughput.
  - At most one reqX_ready is high per cycle. ready may depend on both valids.
- Stage 1 (issue register): captures id, op, signed, a, amt on accept.
- Stage 2: computes the shift from the issue register and pushes {id, y} into the FIFO at the next edge. Guaranteed space means the push never overflows.
- Shift rules:
  - op 00 and op 10: y = a << amt, zero fill.
  - op 01: y = a >> amt, zero fill.
  - op 11, signed=1: sign fill (replicate a[W−1]).
  - op 11, signed=0: zero fill (identical to op 01).
  - amt ≥ W: result 0 for zero-fill cases; all-sign-bits for signed arith right.
- FIFO:
  - 2 entries, in order.
  - res_* show the head entry.
  - Push and pop may occur in the same cycle; count is unchanged in that case.
- Reset:
  - Clears issue register valid, FIFO count/pointers and last_grant←1.
  - In-flight and queued results are discarded and never appear.
  - All outputs reset to 0: res_valid=0, res_id=0, res_y=0, req0_ready=0, req1_ready=0. Readies are also held 0 during the rst cycle.

## Timing

- Handshake in cycle N → issue register valid in N+1 → FIFO entry present in N+2.
- Result latency: res_valid high in cycle N+2 if the FIFO was empty and not blocked.
- Throughput is 1 op/cycle while res_ready stays high.
- res_valid, res_id and res_y are registered (FIFO storage) and stay stable while res_valid & !res_ready.
- res_ready low from cycle 0: exactly two requests are accepted, then both readies stay 0 until a pop.
- Request inputs are sampled only on the handshake cycle. Changing them while ready=0 has no effect.

## Test plan

- Basic ops, W=8, via req0 (one at a time):
  - op00 a=0x81 amt=1 → 0x02
  - op01 a=0x81 amt=3 → 0x10
  - op11 signed a=0x90 amt=2 → 0xE4
  - op11 unsigned a=0x90 amt=2 → 0x24
  - Each result: res_id=0, res_valid at handshake+2.
- Overshift:
  - op11 signed a=0x90 amt=9 → 0xFF
  - op11 signed a=0x70 amt=15 → 0x00
  - op10 a=0xFF amt=8 → 0x00
- Arbitration: both requesters valid continuously for 6 cycles with res_ready=1 → accept order and res_id sequence 0,1,0,1,0,1, one accept per cycle.
- Backpressure: res_ready=0, both valid → exactly 2 accepts (ids 0,1), then readies 0. Raise res_ready → results drain in order, and a new accept occurs in the same cycle as the first pop.
- Reset mid-operation: accept 2 ops, assert rst one cycle, release → res_valid stays 0 with no stale results. The next accept goes to req0 when both are valid.
- Single requester: req1 only, valid for 4 cycles → 4 accepts, res_id=1 each, no bubbles.

Source files
------------

// File: rtl/shift_arb.sv
// shift_arb: round-robin arbiter and two-stage sequencer. Two requesters share one
// shift unit. A granted request is captured in an issue register. The shift is then
// computed and pushed into a 2-entry result FIFO that has its own valid/ready handshake.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   reqN_valid / reqN_ready        request handshake for requester N (0, 1)
//   reqN_op                        00 lsl, 01 lsr, 10 asl, 11 asr
//   reqN_signed                    sign fill for op 11 only
//   reqN_a, reqN_amt               operand and unsigned shift amount
//   res_valid / res_ready          result handshake, head of FIFO
//   res_id, res_y                  issuing requester and shifted result
module shift_arb #(
    parameter int unsigned W  = 8,
    parameter int unsigned SW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [1:0]    req0_op,
    input  logic          req0_signed,
    input  logic [W-1:0]  req0_a,
    input  logic [SW-1:0] req0_amt,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [1:0]    req1_op,
    input  logic          req1_signed,
    input  logic [W-1:0]  req1_a,
    input  logic [SW-1:0] req1_amt,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          res_id,
    output logic [W-1:0]  res_y
);

    logic          last_grant;
    logic          iss_valid;
    logic          iss_id;
    logic [1:0]    iss_op;
    logic          iss_signed;
    logic [W-1:0]  iss_a;
    logic [SW-1:0] iss_amt;

    logic [W:0]    fifo_mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;

    logic          pop;
    logic          push;
    logic [2:0]    occ;
    logic          space;
    logic          grant0;
    logic          grant1;
    logic          acc0;
    logic          acc1;
    logic          accept;
    logic [W-1:0]  shift_y;

    function automatic logic [W-1:0] do_shift(
        input logic [1:0]    op,
        input logic          sgn,
        input logic [W-1:0]  a,
        input logic [SW-1:0] amt
    );
        logic fill;
        logic [W-1:0] y;
        fill = (op == 2'b11) & sgn & a[W-1];
        if (32'(amt) >= W) begin
            y = {W{fill}};
        end else if (!op[0]) begin
            y = a << amt;
        end else begin
            // Logical right shift, then OR the sign into the vacated upper bits.
            y = (a >> amt) | (~({W{1'b1}} >> amt) & {W{fill}});
        end
        return y;
    endfunction

    assign res_valid = (count != 2'd0);
    assign res_id    = fifo_mem[rd_ptr][W];
    assign res_y     = fifo_mem[rd_ptr][W-1:0];

    assign pop   = res_valid & res_ready;
    assign push  = iss_valid;
    // Results owed downstream: queued plus in flight. The pop credit makes res_ready
    // combinationally visible on the readies, which gives full throughput.
    assign occ   = {1'b0, count} + {2'b00, iss_valid};
    assign space = (occ - {2'b00, pop}) < 3'd2;

    assign grant0 = req0_valid & (~req1_valid | last_grant);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant);

    assign req0_ready = ~rst & grant0 & space;
    assign req1_ready = ~rst & grant1 & space;

    assign acc0   = req0_valid & req0_ready;
    assign acc1   = req1_valid & req1_ready;
    assign accept = acc0 | acc1;

    assign shift_y = do_shift(iss_op, iss_signed, iss_a, iss_amt);

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid   <= 1'b0;
            last_grant  <= 1'b1;
            count       <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            iss_valid <= accept;
            if (accept) begin
                last_grant <= acc1;
            end
            if (push) begin
                fifo_mem[wr_ptr] <= {iss_id, shift_y};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // The issue payload is qualified by iss_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            iss_id     <= acc1;
            iss_op     <= acc1 ? req1_op     : req0_op;
            iss_signed <= acc1 ? req1_signed : req0_signed;
            iss_a      <= acc1 ? req1_a      : req0_a;
            iss_amt    <= acc1 ? req1_amt    : req0_amt;
        end
    end

endmodule

// File: tb/tb_shift_arb.sv
// Self-checking bench for shift_arb. A negedge monitor tracks a scoreboard of
// outstanding results and checks every cycle. It checks the readies, res_valid,
// res_id and res_y. Directed table vectors and hand-written sequences cover the
// corner cases. A randomized phase follows them.
module tb_shift_arb;
    localparam int W  = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req0_signed;
    logic [1:0]    req0_op;
    logic [W-1:0]  req0_a;
    logic [SW-1:0] req0_amt;
    logic          req1_valid, req1_ready, req1_signed;
    logic [1:0]    req1_op;
    logic [W-1:0]  req1_a;
    logic [SW-1:0] req1_amt;
    logic          res_valid, res_ready, res_id;
    logic [W-1:0]  res_y;

    always #5 clk = ~clk;

    shift_arb #(.W(W), .SW(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_signed(req0_signed),
        .req0_a     (req0_a),
        .req0_amt   (req0_amt),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_signed(req1_signed),
        .req1_a     (req1_a),
        .req1_amt   (req1_amt),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_y      (res_y)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Shift rules as arithmetic: left = multiply by 2, right = floor-divide by 2.
    function automatic int ref_shift(input int op, input bit sgn, input int a, input int amt);
        longint p;
        int v;
        if (op == 0 || op == 2) begin
            p = longint'(a);
            for (int k = 0; k < amt; k++) p = p * 2;
            return int'(p % (64'd1 << W));
        end
        v = a;
        if (op == 3 && sgn && a >= (1 << (W - 1))) v = a - (1 << W);
        for (int k = 0; k < amt; k++) v = (v < 0 && (v % 2) != 0) ? (v - 1) / 2 : v / 2;
        return v & ((1 << W) - 1);
    endfunction

    typedef struct {
        int id;
        int y;
        int stamp;
    } item_t;

    item_t q[$];
    int    lg  = 1;
    int    cyc = 0;

    always @(negedge clk) begin
        bit vis, pop, space, g0, g1, e0, e1;
        vis = (q.size() > 0) && (cyc >= q[0].stamp + 2);
        if (rst) begin
            chk("rst_ready0", {31'b0, req0_ready}, 0);
            chk("rst_ready1", {31'b0, req1_ready}, 0);
            q.delete();
            lg = 1;
        end else begin
            pop   = vis && res_ready;
            space = (q.size() - int'(pop)) < 2;
            g0 = req0_valid && (!req1_valid || lg == 1);
            g1 = req1_valid && (!req0_valid || lg == 0);
            e0 = g0 && space;
            e1 = g1 && space;
            chk("mon_res_valid", {31'b0, res_valid}, {31'b0, vis});
            if (vis) begin
                chk("mon_res_id", {31'b0, res_id}, q[0].id);
                chk("mon_res_y", {24'b0, res_y}, q[0].y);
            end
            chk("mon_ready0", {31'b0, req0_ready}, {31'b0, e0});
            chk("mon_ready1", {31'b0, req1_ready}, {31'b0, e1});
            if (pop) void'(q.pop_front());
            if (e0) begin
                q.push_back('{0, ref_shift(req0_op, req0_signed, req0_a, req0_amt), cyc});
                lg = 0;
            end else if (e1) begin
                q.push_back('{1, ref_shift(req1_op, req1_signed, req1_a, req1_amt), cyc});
                lg = 1;
            end
        end
        cyc++;
    end

    typedef struct {
        logic [1:0]    op;
        logic          sgn;
        logic [W-1:0]  a;
        logic [SW-1:0] amt;
        logic [W-1:0]  y;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int lat, acc, id;
        int ids[2];
        bit got;

        vecs[0] = '{2'b00, 1'b0, 8'h81, 4'd1,  8'h02};
        vecs[1] = '{2'b01, 1'b0, 8'h81, 4'd3,  8'h10};
        vecs[2] = '{2'b11, 1'b1, 8'h90, 4'd2,  8'hE4};
        vecs[3] = '{2'b11, 1'b0, 8'h90, 4'd2,  8'h24};
        vecs[4] = '{2'b11, 1'b1, 8'h90, 4'd9,  8'hFF};
        vecs[5] = '{2'b11, 1'b1, 8'h70, 4'd15, 8'h00};
        vecs[6] = '{2'b10, 1'b0, 8'hFF, 4'd8,  8'h00};

        rst = 1'b1;
        req0_valid = 0; req0_op = 0; req0_signed = 0; req0_a = 0; req0_amt = 0;
        req1_valid = 0; req1_op = 0; req1_signed = 0; req1_a = 0; req1_amt = 0;
        res_ready = 0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_res_valid", {31'b0, res_valid}, 0);
        chk("reset_res_id", {31'b0, res_id}, 0);
        chk("reset_res_y", {24'b0, res_y}, 0);
        step();

        // Basic ops and overshift, one at a time through req0.
        res_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            req0_valid = 1'b1;
            req0_op = vecs[v].op; req0_signed = vecs[v].sgn;
            req0_a = vecs[v].a; req0_amt = vecs[v].amt;
            @(negedge clk);
            chk("vec_accept", {31'b0, req0_ready}, 1);
            step();
            req0_valid = 1'b0;
            lat = 0;
            got = 1'b0;
            for (int c = 1; c <= 6 && !got; c++) begin
                @(negedge clk);
                if (res_valid) begin
                    got = 1'b1;
                    lat = c;
                    chk("vec_y", {24'b0, res_y}, {24'b0, vecs[v].y});
                    chk("vec_id", {31'b0, res_id}, 0);
                end
                step();
            end
            chk("vec_latency", lat, 2);
        end

        // Arbitration: alternation 0,1,0,1,0,1.
        do_reset();
        res_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'h0F; req0_amt = 4'd2;
        req1_valid = 1'b1; req1_op = 2'b11; req1_signed = 1'b1; req1_a = 8'hC3; req1_amt = 4'd1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            id = req0_ready ? 0 : (req1_ready ? 1 : -1);
            chk("arb_order", id, i % 2);
            step();
        end
        idle_cycles(4);

        // Backpressure: two accepts, then stall, then accept alongside the first pop.
        do_reset();
        res_ready = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                if (acc < 2) ids[acc] = req1_ready ? 1 : 0;
                acc++;
            end
            step();
        end
        chk("bp_accepts", acc, 2);
        chk("bp_first_id", ids[0], 0);
        chk("bp_second_id", ids[1], 1);
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_head", {31'b0, res_id}, 0);
        chk("bp_accept_on_pop", {31'b0, req0_ready | req1_ready}, 1);
        step();
        idle_cycles(5);

        // Reset with two operations in flight.
        do_reset();
        res_ready = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step();
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_stale", {31'b0, res_valid}, 0);
            step();
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        chk("rst_req0_first", {30'b0, req1_ready, req0_ready}, 1);
        step();
        idle_cycles(4);

        // Single requester: back-to-back accepts with no bubbles.
        req1_valid = 1'b1;
        req1_op = 2'b01;
        req1_a = 8'hA5;
        req1_amt = 4'd1;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (req1_ready) acc++;
            step();
        end
        chk("single_accepts", acc, 4);
        idle_cycles(4);

        // Randomized traffic checked by the monitor.
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 79) == 0);
            req0_valid  = ($urandom_range(0, 9) < 7);
            req1_valid  = ($urandom_range(0, 9) < 6);
            req0_op     = 2'($urandom_range(0, 3));
            req1_op     = 2'($urandom_range(0, 3));
            req0_signed = 1'($urandom_range(0, 1));
            req1_signed = 1'($urandom_range(0, 1));
            req0_a      = 8'($urandom_range(0, 255));
            req1_a      = 8'($urandom_range(0, 255));
            req0_amt    = 4'($urandom_range(0, 15));
            req1_amt    = 4'($urandom_range(0, 15));
            res_ready   = ($urandom_range(0, 9) < 7);
            step();
        end
        rst = 1'b0;
        idle_cycles(8);
        chk("drain_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
